shift_pipe2: RTL and testbench
==============================

Name: shift_pipe2

Overview:
- Two-stage pipelined 32-bit barrel shifter for the EX stage.
- Sits between the ID/EX operand register and the ALU result mux.
- Composes fixed-distance right-shift stages of 16, 8, 4, 2 and 1 bits, with one register boundary between the coarse and fine stages.
- Supports SRL, SLL and SRA. Uses a valid/ready handshake so EX stalls propagate correctly.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount width, equal to log2(DATA_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- data_in  in  32  operand to shift.
- shamt  in  5  shift distance, 0..31.
- op  in  2  shift operation: 00 SRL, 01 SLL, 10 SRA, 11 reserved (executes as SRL).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- data_out  out  32  shifted result.

Behaviour:
- Reset (async assert, sync release to the next clk edge):
  - s1_valid = 0, s2_valid = 0, out_valid = 0, data_out = 0.
  - All stage data and control registers are cleared to 0.
  - Reset asserted mid-operation discards any in-flight beats; no partial result appears after release.
- Handshake:
  - A beat transfers on the input when in_valid & in_ready.
  - A beat transfers on the output when out_valid & out_ready.
  - in_valid, data_in, shamt and op must be held stable until accepted; the block does not check this.
- Pipeline enables:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en, combinational from out_ready and the valid flags only, never from in_valid.
- Stage 1, input side, combinational, registered on s1_en:
  - fill = (op == SRA) ? data_in[31] : 0.
  - pre = (op == SLL) ? bitreverse(data_in) : data_in. For SLL, fill is 0.
  - Apply the 16-bit stage if shamt[4], then the 8-bit stage if shamt[3]. Vacated MSBs take fill.
  - Register the partial result, shamt[2:0], the SLL flag, fill, and s1_valid <= in_valid.
- Stage 2, combinational from the s1 registers, registered on s2_en:
  - Apply the 4-, 2- and 1-bit stages per shamt[2], shamt[1], shamt[0], using the registered fill.
  - If the SLL flag is set, bit-reverse the result.
  - data_out <= result, out_valid <= s1_valid.
- Latency and throughput:
  - Exactly 2 cycles from input acceptance to out_valid with no stalls.
  - Throughput is 1 beat per cycle when out_ready is held at 1.
- Stalls:
  - out_ready = 0 with both stages full gives in_ready = 0. data_out holds stable; no beat is lost or duplicated.
  - When out_ready rises, both stages advance in the same cycle.
- Bubbles: when in_valid = 0 and s1_en, s1_valid <= 0. s1_data may keep its old value, but out_valid must not assert for it.
- Boundaries:
  - shamt = 0 returns data_in unchanged for every op.
  - shamt = 31 with SRA returns all bits equal to data_in[31].
  - op = 11 produces exactly the SRL result.
- Simultaneous events: accepting a new beat in the same cycle that the oldest beat leaves is legal and required for full throughput.

Decomposition:
- Package shift_pkg: DATA_W and SHAMT_W constants; op encodings OP_SRL = 2'b00, OP_SLL = 2'b01, OP_SRA = 2'b10, OP_RSV = 2'b11; a bit-reverse function.
- Sub-module shift_stage_n:
  - Combinational: parameter N, inputs data, sel and fill.
  - Output is data >> N with the top N bits set to fill when sel = 1; otherwise data passes through.
  - Instantiated five times, N = 16, 8, 4, 2, 1: 16 and 8 in stage 1, 4, 2 and 1 in stage 2.

Test Plan:
1. Reset: hold rst_n = 0 with random inputs. Required: out_valid = 0, data_out = 0, in_ready = 1 after release.
2. Basic ops, one beat each, out_ready = 1; each result appears 2 cycles after acceptance:
   - data_in = 0x80000F00, shamt = 8, SRL -> 0x0080000F.
   - Same operand, SRA -> 0xFF80000F.
   - Same operand, SLL -> 0x000F0000.
3. Boundaries:
   - shamt = 0, any op on 0xDEADBEEF -> 0xDEADBEEF.
   - shamt = 31 SRA on 0x80000000 -> 0xFFFFFFFF.
   - shamt = 31 SLL on 0x00000001 -> 0x80000000.
   - op = 11, shamt = 4 on 0xF0000000 -> 0x0F000000.
4. Back-to-back: 8 consecutive beats, out_ready = 1, data_in = 0x1 << k, SLL, shamt = k for k = 0..7. Required: 8 consecutive out_valid cycles in order, results 0x1 << (2k).
5. Stall: both stages full, then drop out_ready for 3 cycles. Required: in_ready = 0, data_out stable. Raise out_ready: 2 results drain in order, in_ready = 1 in the same cycle.
6. Reset mid-flight: pulse rst_n low while s1 and s2 hold beats. Required: out_valid = 0 immediately (asynchronously); those results never appear after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants, operation encodings and helpers for the pipelined
// barrel shifter.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    // Shift-amount bits resolved by the second (fine) stage: 4, 2 and 1.
    localparam int FINE_W  = 3;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_e;

    // Everything the fine stage needs to finish a beat.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FINE_W-1:0] shamt_lo;
        logic              sll;
        logic              fill;
    } s1_reg_t;

    // Left shifts reuse the right-shift network by mirroring the word
    // before and after the shift.
    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_pipe2_if.sv
// Operand/result handshake bundle between the EX operand register, the
// shifter and the ALU result mux.
interface shift_pipe2_if;
    import shift_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   data_in;
    logic [SHAMT_W-1:0]  shamt;
    logic [1:0]          op;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   data_out;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid,
        output data_in,
        output shamt,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );

    // The shifter itself.
    modport slave (
        input  in_valid,
        input  data_in,
        input  shamt,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );

endinterface

// File: rtl/shift_stage_n.sv
// One fixed-distance logical/arithmetic right-shift stage. When selected,
// the word moves right by N and the vacated top bits take the fill value.
module shift_stage_n
    import shift_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic              sel,
    input  logic              fill,
    output logic [DATA_W-1:0] result
);

    // Shift by N or pass through.
    always_comb begin
        result = data;
        if (sel) begin
            result = {{N{fill}}, data[DATA_W-1:N]};
        end
    end

endmodule

// File: rtl/shift_pipe2.sv
// Two-stage pipelined 32-bit barrel shifter (SRL, SLL, SRA). Stage 1
// resolves the 16- and 8-bit distances, stage 2 the 4-, 2- and 1-bit
// distances. A valid/ready handshake lets EX stalls back up through both
// stages without losing or duplicating a beat.
module shift_pipe2
    import shift_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    shift_pipe2_if.slave   bus
);

    logic               s1_valid;
    s1_reg_t            s1_q;
    s1_reg_t            s1_d;
    logic               s2_valid;
    logic [DATA_W-1:0]  s2_data;

    logic               s1_en;
    logic               s2_en;

    logic               in_sll;
    logic               in_fill;
    logic [DATA_W-1:0]  pre;
    logic [DATA_W-1:0]  after16;
    logic [DATA_W-1:0]  after8;
    logic [DATA_W-1:0]  after4;
    logic [DATA_W-1:0]  after2;
    logic [DATA_W-1:0]  after1;
    logic [DATA_W-1:0]  s2_result;

    // Stage enables: a stage may load when it is empty or its contents move
    // on this cycle. in_ready never looks at in_valid.
    always_comb begin
        s2_en = !s2_valid || bus.out_ready;
        s1_en = !s1_valid || s2_en;
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid;
    assign bus.data_out  = s2_data;

    // Input decode: SLL runs on the mirrored word with zero fill; SRA fills
    // with the sign bit; SRL and the reserved code fill with zero.
    always_comb begin
        in_sll  = (bus.op == OP_SLL);
        in_fill = (bus.op == OP_SRA) ? bus.data_in[DATA_W-1] : 1'b0;
        pre     = in_sll ? bit_reverse(bus.data_in) : bus.data_in;
    end

    shift_stage_n #(.N(16)) u_stage16 (
        .data   (pre),
        .sel    (bus.shamt[4]),
        .fill   (in_fill),
        .result (after16)
    );

    shift_stage_n #(.N(8)) u_stage8 (
        .data   (after16),
        .sel    (bus.shamt[3]),
        .fill   (in_fill),
        .result (after8)
    );

    // Collect the coarse partial result and what the fine stage still needs.
    always_comb begin
        s1_d          = '0;
        s1_d.data     = after8;
        s1_d.shamt_lo = bus.shamt[FINE_W-1:0];
        s1_d.sll      = in_sll;
        s1_d.fill     = in_fill;
    end

    // Stage 1 register; a bubble clears s1_valid but may leave stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_q     <= s1_d;
            s1_valid <= bus.in_valid;
        end
    end

    shift_stage_n #(.N(4)) u_stage4 (
        .data   (s1_q.data),
        .sel    (s1_q.shamt_lo[2]),
        .fill   (s1_q.fill),
        .result (after4)
    );

    shift_stage_n #(.N(2)) u_stage2 (
        .data   (after4),
        .sel    (s1_q.shamt_lo[1]),
        .fill   (s1_q.fill),
        .result (after2)
    );

    shift_stage_n #(.N(1)) u_stage1 (
        .data   (after2),
        .sel    (s1_q.shamt_lo[0]),
        .fill   (s1_q.fill),
        .result (after1)
    );

    // Undo the input mirroring for left shifts.
    always_comb begin
        s2_result = s1_q.sll ? bit_reverse(after1) : after1;
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else if (s2_en) begin
            s2_data  <= s2_result;
            s2_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_shift_pipe2.sv
// Self-checking bench for shift_pipe2: directed scenarios plus a randomized
// run checked against a queue-based arithmetic reference model.
module tb_shift_pipe2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] exp_q[$];

    shift_pipe2_if sif ();

    shift_pipe2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain shift operators on the whole word.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input logic [1:0] o);
        case (o)
            2'b01:   return d << s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d >> s;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sif.in_valid  = 1'($urandom_range(0, 1));
            sif.data_in   = $urandom;
            sif.shamt     = 5'($urandom_range(0, 31));
            sif.op        = 2'($urandom_range(0, 3));
            sif.out_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (sif.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_out_valid: got %b want 0", sif.out_valid);
            end
            total++;
            if (sif.data_out !== 32'h0) begin
                bad++;
                $display("FAIL reset_data_out: got %h want 00000000", sif.data_out);
            end
        end
        @(negedge clk);
        rst_n         = 1'b1;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        #1;
        total++;
        if (sif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", sif.in_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (sif.out_valid !== 1'b0 || sif.data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_release_out: got valid=%b data=%h want 0/00000000",
                     sif.out_valid, sif.data_out);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d[3];
        logic [1:0]  o[3];
        logic [31:0] e[3];
        d = '{32'h80000F00, 32'h80000F00, 32'h80000F00};
        o = '{2'b00, 2'b10, 2'b01};
        e = '{32'h0080000F, 32'hFF80000F, 32'h000F0000};
        sif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sif.in_valid = 1'b1;
            sif.data_in  = d[i];
            sif.shamt    = 5'd8;
            sif.op       = o[i];
            #1;
            total++;
            if (sif.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_in_ready[%0d]: got %b want 1", i, sif.in_ready);
            end
            @(negedge clk);
            sif.in_valid = 1'b0;
            #1;
            total++;
            if (sif.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL basic_early_valid[%0d]: got %b want 0", i, sif.out_valid);
            end
            @(negedge clk);
            #1;
            total++;
            if (sif.out_valid !== 1'b1 || sif.data_out !== e[i]) begin
                bad++;
                $display("FAIL basic_result[%0d]: got valid=%b data=%h want 1/%h",
                         i, sif.out_valid, sif.data_out, e[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] d[7];
        logic [4:0]  s[7];
        logic [1:0]  o[7];
        logic [31:0] e[7];
        d = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
              32'h80000000, 32'h00000001, 32'hF0000000};
        s = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd4};
        o = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11};
        e = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
              32'hFFFFFFFF, 32'h80000000, 32'h0F000000};
        sif.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sif.in_valid = 1'b1;
            sif.data_in  = d[i];
            sif.shamt    = s[i];
            sif.op       = o[i];
            @(negedge clk);
            sif.in_valid = 1'b0;
            @(negedge clk);
            #1;
            total++;
            if (sif.out_valid !== 1'b1 || sif.data_out !== e[i]) begin
                bad++;
                $display("FAIL boundary[%0d]: got valid=%b data=%h want 1/%h",
                         i, sif.out_valid, sif.data_out, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        sif.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) begin
                sif.in_valid = 1'b1;
                sif.data_in  = 32'h1 << c;
                sif.shamt    = 5'(c);
                sif.op       = 2'b01;
            end else begin
                sif.in_valid = 1'b0;
            end
            #1;
            if (c >= 2 && c < 10) begin
                e = 32'h1 << (2 * (c - 2));
                total++;
                if (sif.out_valid !== 1'b1 || sif.data_out !== e) begin
                    bad++;
                    $display("FAIL b2b_result[%0d]: got valid=%b data=%h want 1/%h",
                             c - 2, sif.out_valid, sif.data_out, e);
                end
            end else begin
                total++;
                if (sif.out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle[cycle %0d]: got valid=%b want 0", c, sif.out_valid);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d[3];
        logic [4:0]  s[3];
        logic [1:0]  o[3];
        logic [31:0] e[3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            s[i] = 5'($urandom_range(0, 31));
            o[i] = 2'($urandom_range(0, 3));
            e[i] = model(d[i], s[i], o[i]);
        end
        sif.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                sif.in_valid = 1'b1;
                sif.data_in  = d[c];
                sif.shamt    = s[c];
                sif.op       = o[c];
            end else if (c >= 6) begin
                sif.in_valid = 1'b0;
            end
            sif.out_ready = !(c >= 2 && c <= 4);
            #1;
            if (c < 2) begin
                total++;
                if (sif.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_fill_ready[%0d]: got %b want 1", c, sif.in_ready);
                end
            end else if (c <= 4) begin
                total++;
                if (sif.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready[%0d]: got %b want 0", c, sif.in_ready);
                end
                total++;
                if (sif.out_valid !== 1'b1 || sif.data_out !== e[0]) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: got valid=%b data=%h want 1/%h",
                             c, sif.out_valid, sif.data_out, e[0]);
                end
            end else if (c <= 7) begin
                if (c == 5) begin
                    total++;
                    if (sif.in_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_release_ready: got %b want 1", sif.in_ready);
                    end
                end
                total++;
                if (sif.out_valid !== 1'b1 || sif.data_out !== e[c-5]) begin
                    bad++;
                    $display("FAIL stall_drain[%0d]: got valid=%b data=%h want 1/%h",
                             c - 5, sif.out_valid, sif.data_out, e[c-5]);
                end
            end else begin
                total++;
                if (sif.out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_empty: got valid=%b want 0", sif.out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        sif.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sif.in_valid = (c < 2);
            sif.data_in  = $urandom | 32'h1;
            sif.shamt    = 5'($urandom_range(0, 31));
            sif.op       = 2'($urandom_range(0, 3));
        end
        #1;
        total++;
        if (sif.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midflight_loaded: got valid=%b want 1", sif.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (sif.out_valid !== 1'b0 || sif.data_out !== 32'h0) begin
            bad++;
            $display("FAIL midflight_async_clear: got valid=%b data=%h want 0/00000000",
                     sif.out_valid, sif.data_out);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        sif.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if (sif.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midflight_ghost[%0d]: got valid=%b data=%h want 0",
                         c, sif.out_valid, sif.data_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic        held;
        logic [31:0] e;
        held = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c < 400) begin
                sif.out_ready = ($urandom_range(0, 9) < 7);
                if (!held) begin
                    sif.in_valid = ($urandom_range(0, 9) < 7);
                    sif.data_in  = $urandom;
                    sif.shamt    = 5'($urandom_range(0, 31));
                    sif.op       = 2'($urandom_range(0, 3));
                end
            end else begin
                sif.out_ready = 1'b1;
                if (!held) sif.in_valid = 1'b0;
            end
            #1;
            if (sif.out_valid && sif.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL random_extra[cycle %0d]: got data=%h want no beat", c, sif.data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (sif.data_out !== e) begin
                        bad++;
                        $display("FAIL random_data[cycle %0d]: got %h want %h", c, sif.data_out, e);
                    end
                end
            end
            if (sif.in_valid && sif.in_ready) begin
                exp_q.push_back(model(sif.data_in, sif.shamt, sif.op));
                held = 1'b0;
            end else begin
                held = sif.in_valid;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_lost: got %0d beats undelivered want 0", exp_q.size());
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.data_in   = '0;
        sif.shamt     = '0;
        sif.op        = '0;
        sif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
